mem_arbiter: RTL and testbench

Round-robin read arbiter sharing the single heap memory read port among `NumReq` requesters (evaluator, printer, future GC walker). Each requester gets a level request / one-cycle response handshake. The arbiter owns the memory's `req`/`addr_in` inputs and collects `data_ready`/`data_out`. A watchdog converts a missing memory response into an error response.

---
 rtl/lisp_defs.sv | 14 +
 rtl/rr_picker.sv | 32 +++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lisp_defs.sv
// Shared definitions for the heap memory and its read-port arbiter.
package lisp_defs;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } mem_arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request bit searching upward
// from last_grant+1, wrapping modulo NumReq.
module rr_picker #(
    parameter int NumReq = 2,
    parameter int IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] i_req,
    input  logic [IdxW-1:0]   i_last_grant,
    output logic              o_found,
    output logic [IdxW-1:0]   o_idx
);

    int w_sum;

    // Scan from the farthest candidate down so the nearest one overwrites last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_sum   = 0;
        for (int k = NumReq; k >= 1; k--) begin
            w_sum = int'(i_last_grant) + k;
            if (w_sum >= NumReq) begin
                w_sum = w_sum - NumReq;
            end
            if (i_req[w_sum]) begin
                o_found = 1'b1;
                o_idx   = IdxW'(w_sum);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the heap memory read port among NumReq
// requesters, with a watchdog that turns a missing memory reply into an error.
module mem_arbiter
    import lisp_defs::*;
#(
    parameter int NumReq        = 2,
    parameter int AddrWidth     = MEM_ADDR_W,
    parameter int TimeoutCycles = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NumReq-1:0]          rq_valid,
    input  logic [AddrWidth-1:0]       rq_addr [NumReq],
    output logic [NumReq-1:0]          rs_valid,
    output logic [NumReq-1:0]          rs_err,
    output logic [MEM_DATA_W-1:0]      rs_data,
    output logic                       mem_req,
    output logic [AddrWidth-1:0]       mem_addr,
    input  logic                       mem_data_ready,
    input  logic [MEM_DATA_W-1:0]      mem_data_out,
    output logic                       busy,
    output logic [$clog2(NumReq)-1:0]  grant_id
);

    localparam int IdxW = $clog2(NumReq);
    localparam int CntW = $clog2(TimeoutCycles);

    mem_arb_state_t          r_state, w_state_next;
    logic [CntW-1:0]         r_cnt, w_cnt_next;
    logic [IdxW-1:0]         r_last_grant, w_last_grant_next;
    logic [IdxW-1:0]         r_grant_id, w_grant_id_next;
    logic                    r_mem_req, w_mem_req_next;
    logic [AddrWidth-1:0]    r_mem_addr, w_mem_addr_next;
    logic [NumReq-1:0]       r_rs_valid, w_rs_valid_next;
    logic [NumReq-1:0]       r_rs_err, w_rs_err_next;
    logic [MEM_DATA_W-1:0]   r_rs_data, w_rs_data_next;
    logic                    r_busy;

    logic                    w_found;
    logic [IdxW-1:0]         w_pick_idx;
    logic [NumReq-1:0]       w_grant_onehot;

    rr_picker #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_picker (
        .i_req        (rq_valid),
        .i_last_grant (r_last_grant),
        .o_found      (w_found),
        .o_idx        (w_pick_idx)
    );

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_onehot
        assign w_grant_onehot[gi] = (r_grant_id == IdxW'(gi));
    end

    // mem_req and the response strobes are only ever high for one cycle,
    // so they default low; everything else holds unless a transition moves it.
    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_last_grant_next = r_last_grant;
        w_grant_id_next   = r_grant_id;
        w_mem_req_next    = 1'b0;
        w_mem_addr_next   = r_mem_addr;
        w_rs_valid_next   = '0;
        w_rs_err_next     = '0;
        w_rs_data_next    = r_rs_data;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_next      = ISSUE;
                    w_grant_id_next   = w_pick_idx;
                    w_last_grant_next = w_pick_idx;
                    w_mem_addr_next   = rq_addr[w_pick_idx];
                    w_mem_req_next    = 1'b1;
                end
            end
            ISSUE: begin
                w_state_next = WAIT;
                w_cnt_next   = '0;
            end
            WAIT: begin
                if (mem_data_ready) begin
                    w_state_next    = RESP;
                    w_rs_valid_next = w_grant_onehot;
                    w_rs_data_next  = mem_data_out;
                end else if (r_cnt == CntW'(TimeoutCycles - 1)) begin
                    w_state_next    = RESP;
                    w_rs_valid_next = w_grant_onehot;
                    w_rs_err_next   = w_grant_onehot;
                    w_rs_data_next  = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_last_grant <= IdxW'(NumReq - 1);
            r_grant_id   <= '0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_rs_valid   <= '0;
            r_rs_err     <= '0;
            r_rs_data    <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_last_grant <= w_last_grant_next;
            r_grant_id   <= w_grant_id_next;
            r_mem_req    <= w_mem_req_next;
            r_mem_addr   <= w_mem_addr_next;
            r_rs_valid   <= w_rs_valid_next;
            r_rs_err     <= w_rs_err_next;
            r_rs_data    <= w_rs_data_next;
            r_busy       <= (w_state_next != IDLE);
        end
    end

    assign rs_valid = r_rs_valid;
    assign rs_err   = r_rs_err;
    assign rs_data  = r_rs_data;
    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
    assign busy     = r_busy;
    assign grant_id = r_grant_id;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus randomized traffic
// against a memory model with address-dependent reply delay.
module tb_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int T  = 8;
    localparam int IW = $clog2(N);
    localparam logic [15:0] LISP_NIL = 16'h8000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      rq_valid;
    logic [AW-1:0]     rq_addr [N];
    logic [N-1:0]      rs_valid;
    logic [N-1:0]      rs_err;
    logic [15:0]       rs_data;
    logic              mem_req;
    logic [AW-1:0]     mem_addr;
    logic              mem_data_ready;
    logic [15:0]       mem_data_out;
    logic              busy;
    logic [IW-1:0]     grant_id;

    mem_arbiter #(
        .NumReq        (N),
        .AddrWidth     (AW),
        .TimeoutCycles (T)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rq_valid       (rq_valid),
        .rq_addr        (rq_addr),
        .rs_valid       (rs_valid),
        .rs_err         (rs_err),
        .rs_data        (rs_data),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_data_ready (mem_data_ready),
        .mem_data_out   (mem_data_out),
        .busy           (busy),
        .grant_id       (grant_id)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          req;
        logic [15:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mem_arr [256];
    int          mem_mode = 0;   // 0: reply next cycle, 1: delay = addr[3:0], 2: never reply
    bit          spur_req = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int delay_of(logic [AW-1:0] a);
        return (mem_mode == 1) ? int'(a[3:0]) : 0;
    endfunction

    // ---------------- memory model ----------------
    int          pend = 0;
    int          pcnt = 0;
    logic [15:0] pdata = '0;
    initial begin
        mem_data_ready = 1'b0;
        mem_data_out   = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_data_ready = 1'b0;
            if (!rst_n) begin
                pend = 0;
            end else begin
                if (spur_req) begin
                    mem_data_ready = 1'b1;
                    mem_data_out   = 16'hBEEF;
                    spur_req       = 1'b0;
                end
                if (pend != 0) begin
                    if (pcnt == 0) begin
                        mem_data_ready = 1'b1;
                        mem_data_out   = pdata;
                        pend           = 0;
                    end else begin
                        pcnt--;
                    end
                end
                if (mem_req) begin
                    pcnt  = delay_of(mem_addr);
                    pend  = (mem_mode != 2 && pcnt <= T - 1) ? 1 : 0;
                    pdata = mem_arr[mem_addr[7:0]];
                end
            end
        end
    end

    // ---------------- monitor ----------------
    logic [N-1:0] mon_prev_rq   = '0;
    logic         mon_prev_mreq = 1'b0;
    int           mon_last      = N - 1;
    int           mon_mreq_cyc  = 0;

    task automatic mon_step();
        int   g;
        int   c;
        int   k;
        int   pos;
        exp_t e;
        if (mem_req) begin
            chk("mem_req_single_pulse", {31'd0, mon_prev_mreq}, 32'd0);
            g = -1;
            for (int j = 1; j <= N; j++) begin
                c = (mon_last + j) % N;
                if (g < 0 && mon_prev_rq[c]) g = c;
            end
            if (g < 0) begin
                checks++;
                failures++;
                $display("FAIL grant_without_request actual=mem_req required=no_request (cycle %0d)", cyc);
            end else begin
                chk("grant_id", 32'(grant_id), 32'(g));
                chk("mem_addr", 32'(mem_addr), 32'(rq_addr[g]));
                mon_last = g;
            end
            mon_mreq_cyc = cyc;
        end
        chk("rs_err_qualified", 32'(rs_err & ~rs_valid), 32'd0);
        if (rs_valid != '0) begin
            chk("rs_valid_onehot", {31'd0, $onehot(rs_valid)}, 32'd1);
            k = 0;
            for (int j = N - 1; j >= 0; j--) if (rs_valid[j]) k = j;
            pos = -1;
            for (int j = 0; j < sb.size(); j++) begin
                if (pos < 0 && sb[j].req == k) pos = j;
            end
            if (pos < 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_response actual=rs_valid[%0d] required=none (cycle %0d)", k, cyc);
            end else begin
                e = sb[pos];
                sb.delete(pos);
                chk("rs_err", {31'd0, rs_err[k]}, {31'd0, e.err});
                chk("rs_data", 32'(rs_data), 32'(e.data));
                chk("latency_from_mem_req", 32'(cyc - mon_mreq_cyc), 32'(e.lat));
            end
        end
        mon_prev_rq   = rq_valid;
        mon_prev_mreq = mem_req;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_last      = N - 1;
                mon_prev_rq   = '0;
                mon_prev_mreq = 1'b0;
            end else begin
                mon_step();
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(int i, logic [AW-1:0] a);
        exp_t e;
        int   d;
        d        = delay_of(a);
        e.req    = i;
        e.err    = (mem_mode == 2) || (d > T - 1);
        e.data   = e.err ? 16'h0000 : mem_arr[a[7:0]];
        e.lat    = e.err ? T + 1 : d + 2;
        sb.push_back(e);
        rq_addr[i]  = a;
        rq_valid[i] = 1'b1;
    endtask

    task automatic wait_resp(int i, output int c);
        int n;
        n = 0;
        tick();
        while (!rs_valid[i] && n < 100) begin
            tick();
            n++;
        end
        if (!rs_valid[i]) begin
            checks++;
            failures++;
            $display("FAIL wait_resp_%0d actual=no_rs_valid required=rs_valid", i);
        end
        c = cyc;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (rq_valid != '0 && n < 400) begin
            tick();
            for (int i = 0; i < N; i++) if (rq_valid[i] && rs_valid[i]) rq_valid[i] = 1'b0;
            n++;
        end
        if (rq_valid != '0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0h required=0", rq_valid);
        end
    endtask

    task automatic random_phase(int mode, int ncyc);
        logic [AW-1:0] a;
        mem_mode = mode;
        repeat (ncyc) begin
            tick();
            for (int i = 0; i < N; i++) begin
                a = AW'($urandom_range(255));
                if (rq_valid[i] && rs_valid[i]) begin
                    if ($urandom_range(3) != 0) issue(i, a);
                    else rq_valid[i] = 1'b0;
                end else if (!rq_valid[i] && $urandom_range(2) == 0) begin
                    issue(i, a);
                end
            end
        end
        drain();
    endtask

    int c1;
    int c2;
    int nresp;
    int guard;

    initial begin
        for (int j = 0; j < 256; j++) mem_arr[j] = 16'($urandom);
        mem_arr[1] = 16'h0004;
        mem_arr[2] = 16'h0000;
        mem_arr[3] = LISP_NIL;
        mem_arr[4] = 16'h789A;
        rst_n    = 1'b0;
        rq_valid = '0;
        for (int i = 0; i < N; i++) rq_addr[i] = '0;

        #2;
        chk("reset_rs_valid", 32'(rs_valid), 32'd0);
        chk("reset_rs_err", 32'(rs_err), 32'd0);
        chk("reset_rs_data", 32'(rs_data), 32'd0);
        chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_grant_id", 32'(grant_id), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // single read: mem_req in cycle 1, response in cycle 3
        mem_mode = 0;
        issue(0, 16'd4);
        tick();
        chk("single_mem_req_cycle1", {31'd0, mem_req}, 32'd1);
        chk("single_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("single_mem_req_cycle2", {31'd0, mem_req}, 32'd0);
        wait_resp(0, c1);
        chk("single_rs_data", 32'(rs_data), 32'h789A);
        rq_valid[0] = 1'b0;
        tick();

        // contention between 0 and 1, each re-requesting immediately
        issue(0, 16'd2);
        issue(1, 16'd3);
        nresp = 0;
        guard = 0;
        while (nresp < 4 && guard < 100) begin
            tick();
            guard++;
            for (int i = 0; i < N; i++) begin
                if (rq_valid[i] && rs_valid[i]) begin
                    nresp++;
                    if (nresp < 4) issue(i, rq_addr[i]);
                    else rq_valid[i] = 1'b0;
                end
            end
        end
        chk("contention_responses", 32'(nresp), 32'd4);
        drain();

        // back-to-back from requester 1
        issue(1, 16'd1);
        wait_resp(1, c1);
        issue(1, 16'd4);
        wait_resp(1, c2);
        chk("b2b_spacing", 32'(c2 - c1), 32'd4);
        rq_valid[1] = 1'b0;
        tick();

        // timeout, then a normal read
        mem_mode = 2;
        issue(0, 16'd5);
        wait_resp(0, c1);
        chk("timeout_rs_err", 32'(rs_err), 32'd1);
        rq_valid[0] = 1'b0;
        tick();
        mem_mode = 0;
        issue(0, 16'd4);
        wait_resp(0, c1);
        chk("after_timeout_rs_err", 32'(rs_err), 32'd0);
        rq_valid[0] = 1'b0;
        tick();
        tick();

        // spurious data_ready while idle
        spur_req = 1'b1;
        repeat (5) begin
            tick();
            chk("spurious_busy", {31'd0, busy}, 32'd0);
            chk("spurious_rs_valid", 32'(rs_valid), 32'd0);
        end

        // asynchronous reset during WAIT
        mem_mode = 2;
        issue(1, 16'd6);
        tick();
        tick();
        tick();
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("async_rst_rs_valid", 32'(rs_valid), 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_grant_id", 32'(grant_id), 32'd0);
        chk("async_rst_mem_addr", 32'(mem_addr), 32'd0);
        sb.delete();
        rq_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();
        mem_mode = 0;
        issue(1, 16'd3);
        issue(0, 16'd2);
        wait_resp(0, c1);
        rq_valid[0] = 1'b0;
        wait_resp(1, c2);
        rq_valid[1] = 1'b0;
        tick();

        // randomized traffic
        random_phase(0, 400);
        random_phase(1, 600);

        repeat (4) tick();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

endmodule
